spi_cmd_rx: RTL

SPI slave command receiver sitting directly upstream of the real-time command register `wcm`. It deserialises framed SPI transactions from the microcontroller, in the `CLK` (48 MHz) domain, into the complete command field set plus `TIME_INIT`. It presents all fields atomically and strobes `SPI_WR` into `wcm`. It also owns the `SYS_TIME_UPDATE` request level consumed by `MASTER_START`.

---
 rtl/spi_cmd_pkg.sv | 39 +++
 rtl/spi_in_sync.sv | 36 +++
 rtl/spi_cmd_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants, field layout, receiver state encoding and CRC-8 helper for spi_cmd_rx.
package spi_cmd_pkg;

   localparam logic [7:0] OP_CMD     = 8'hA1;
   localparam logic [7:0] OP_TIME    = 8'hB2;
   localparam int         CMD_BYTES  = 43;
   localparam int         TIME_BYTES = 8;
   localparam logic [7:0] CRC_POLY   = 8'h07;

   // LSB positions inside the shadow register once a full command payload has been shifted in
   localparam int OFS_FREQ   = 296;
   localparam int OFS_STEP   = 248;
   localparam int OFS_RATE   = 216;
   localparam int OFS_TSTART = 152;
   localparam int OFS_NIMP   = 136;
   localparam int OFS_TYPE   = 128;
   localparam int OFS_TI     = 96;
   localparam int OFS_TP     = 64;
   localparam int OFS_TB1    = 32;
   localparam int OFS_TB2    = 0;
   localparam int OFS_TINIT  = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPCODE,
      ST_PAYLOAD,
      ST_DISCARD,
      ST_COMMIT
   } rx_state_t;

   function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronisers for the SPI pins plus SCK-rise and CS_N edge detection in the CLK domain.
module spi_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic sck,
   input  logic cs_n,
   input  logic mosi,
   output logic sck_rise,
   output logic cs_rise,
   output logic cs_fall,
   output logic mosi_s
);

   logic [2:0] sck_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   // Reset to the "CS_N low" level so a frame already in progress at release shows no falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_q  <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], sck};
         cs_q   <= {cs_q[1:0], cs_n};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];
   assign cs_fall  = ~cs_q[1] & cs_q[2];
   assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI slave receiving 0xA1 command / 0xB2 time frames and presenting them atomically to wcm.
// Define SPI_CRC_EN to require and check a trailing CRC-8 byte on every frame.
module spi_cmd_rx #(
   parameter int CMD_BYTES  = spi_cmd_pkg::CMD_BYTES,
   parameter int TIME_BYTES = spi_cmd_pkg::TIME_BYTES
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        SCK,
   input  logic        CS_N,
   input  logic        MOSI,
   input  logic        SYS_TIME_UPDATE_OK,
   output logic [47:0] FREQ,
   output logic [47:0] FREQ_STEP,
   output logic [31:0] FREQ_RATE,
   output logic [63:0] TIME_START,
   output logic [15:0] N_impulse,
   output logic [1:0]  TYPE_impulse,
   output logic [31:0] Interval_Ti,
   output logic [31:0] Interval_Tp,
   output logic [31:0] Tblank1,
   output logic [31:0] Tblank2,
   output logic        SPI_WR,
   output logic [63:0] TIME_INIT,
   output logic        SYS_TIME_UPDATE,
   output logic        FRAME_ERR
);
   import spi_cmd_pkg::*;

   localparam int SH_W = CMD_BYTES * 8;
`ifdef SPI_CRC_EN
   localparam int CRC_BYTES = 1;
`else
   localparam int CRC_BYTES = 0;
`endif
   localparam logic [5:0] PAY_CMD  = 6'(CMD_BYTES);
   localparam logic [5:0] PAY_TIME = 6'(TIME_BYTES);
   localparam logic [5:0] LEN_CMD  = 6'(CMD_BYTES + CRC_BYTES);
   localparam logic [5:0] LEN_TIME = 6'(TIME_BYTES + CRC_BYTES);

   logic            sck_rise, cs_rise, cs_fall, mosi_s;
   rx_state_t       state, nxt;
   logic [6:0]      byte_sr;
   logic [7:0]      cur_byte;
   logic [2:0]      bit_cnt;
   logic [5:0]      byte_cnt;
   logic            is_cmd, is_time;
   logic [SH_W-1:0] shadow;
   logic [5:0]      pay_len, frame_len;
   logic            len_ok, crc_ok;
   logic            commit_cmd, commit_time, reject;
   logic            wr_pend;
   logic            unused_type_bits;

   spi_in_sync u_sync (
      .clk      (CLK),
      .rst      (RESET),
      .sck      (SCK),
      .cs_n     (CS_N),
      .mosi     (MOSI),
      .sck_rise (sck_rise),
      .cs_rise  (cs_rise),
      .cs_fall  (cs_fall),
      .mosi_s   (mosi_s)
   );

   assign cur_byte  = {byte_sr, mosi_s};
   assign pay_len   = is_cmd ? PAY_CMD : PAY_TIME;
   assign frame_len = is_cmd ? LEN_CMD : LEN_TIME;
   assign len_ok    = (bit_cnt == 3'd0) && (byte_cnt == frame_len);
   assign unused_type_bits = ^shadow[OFS_TYPE+2 +: 6];

`ifdef SPI_CRC_EN
   logic [7:0] crc_run, crc_rx;
   assign crc_ok = (crc_run == crc_rx);
`else
   assign crc_ok = 1'b1;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= ST_IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt         = state;
      commit_cmd  = 1'b0;
      commit_time = 1'b0;
      reject      = 1'b0;
      case (state)
         ST_IDLE:    if (cs_fall) nxt = ST_OPCODE;
         ST_OPCODE:
            if (cs_rise) nxt = ST_COMMIT;
            else if (sck_rise && bit_cnt == 3'd7)
               nxt = (cur_byte == OP_CMD || cur_byte == OP_TIME) ? ST_PAYLOAD : ST_DISCARD;
         ST_PAYLOAD: if (cs_rise) nxt = ST_COMMIT;
         ST_DISCARD: if (cs_rise) nxt = ST_COMMIT;
         ST_COMMIT: begin
            nxt = ST_IDLE;
            if (is_cmd && len_ok && crc_ok)       commit_cmd  = 1'b1;
            else if (is_time && len_ok && crc_ok) commit_time = 1'b1;
            else                                  reject      = 1'b1;
         end
         default:    nxt = ST_IDLE;
      endcase
   end

   // Deserialiser: opcode byte sets the frame kind, payload bytes land in the shadow register,
   // anything past the payload (the CRC byte, or overrun) is only counted.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         byte_sr  <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         is_cmd   <= 1'b0;
         is_time  <= 1'b0;
         shadow   <= '0;
`ifdef SPI_CRC_EN
         crc_run  <= '0;
         crc_rx   <= '0;
`endif
      end else if (state == ST_IDLE && cs_fall) begin
         bit_cnt  <= '0;
         byte_cnt <= '0;
         is_cmd   <= 1'b0;
         is_time  <= 1'b0;
      end else if (sck_rise && (state == ST_OPCODE || state == ST_PAYLOAD)) begin
         byte_sr <= cur_byte[6:0];
         bit_cnt <= bit_cnt + 3'd1;
         if (state == ST_OPCODE) begin
            if (bit_cnt == 3'd7) begin
               is_cmd  <= (cur_byte == OP_CMD);
               is_time <= (cur_byte == OP_TIME);
`ifdef SPI_CRC_EN
               crc_run <= crc8_update(8'h00, cur_byte);
`endif
            end
         end else begin
            if (byte_cnt < pay_len) shadow <= {shadow[SH_W-2:0], mosi_s};
            if (bit_cnt == 3'd7) begin
               if (byte_cnt != 6'h3f) byte_cnt <= byte_cnt + 6'd1;
`ifdef SPI_CRC_EN
               if (byte_cnt < pay_len) crc_run <= crc8_update(crc_run, cur_byte);
               else                    crc_rx  <= cur_byte;
`endif
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         FREQ            <= '0;
         FREQ_STEP       <= '0;
         FREQ_RATE       <= '0;
         TIME_START      <= '0;
         N_impulse       <= '0;
         TYPE_impulse    <= '0;
         Interval_Ti     <= '0;
         Interval_Tp     <= '0;
         Tblank1         <= '0;
         Tblank2         <= '0;
         TIME_INIT       <= '0;
         wr_pend         <= 1'b0;
         SPI_WR          <= 1'b0;
         FRAME_ERR       <= 1'b0;
         SYS_TIME_UPDATE <= 1'b0;
      end else begin
         if (commit_cmd) begin
            FREQ         <= shadow[OFS_FREQ   +: 48];
            FREQ_STEP    <= shadow[OFS_STEP   +: 48];
            FREQ_RATE    <= shadow[OFS_RATE   +: 32];
            TIME_START   <= shadow[OFS_TSTART +: 64];
            N_impulse    <= shadow[OFS_NIMP   +: 16];
            TYPE_impulse <= shadow[OFS_TYPE   +: 2];
            Interval_Ti  <= shadow[OFS_TI     +: 32];
            Interval_Tp  <= shadow[OFS_TP     +: 32];
            Tblank1      <= shadow[OFS_TB1    +: 32];
            Tblank2      <= shadow[OFS_TB2    +: 32];
         end
         if (commit_time) TIME_INIT <= shadow[OFS_TINIT +: 64];
         // Strobe trails the field load so wcm always sees settled fields.
         wr_pend   <= commit_cmd;
         SPI_WR    <= wr_pend;
         FRAME_ERR <= reject;
         if (commit_time)             SYS_TIME_UPDATE <= 1'b1;
         else if (SYS_TIME_UPDATE_OK) SYS_TIME_UPDATE <= 1'b0;
      end
   end

endmodule
